// File: rtl/dataflow_collect_pkg.sv
// Shared types for the dataflow collector: default word format, lane vector,
// collector state encoding and the beat-index width helper.
package dataflow_pkg;

  localparam int IL_DEF = 4;
  localparam int FL_DEF = 16;
  localparam int W_DEF  = IL_DEF + FL_DEF;

  typedef logic signed [W_DEF-1:0] word_t;
  typedef word_t lane_t [16];

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat index width: clog2 of the beat count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dataflow_collect_if.sv
// Frame-in / beat-out stream bundle of the dataflow collector.
// master: the collector side (accepts frames, drives the beat stream).
// slave:  the surrounding environment (PE array producer and output buffer).
interface dataflow_collect_if
  import dataflow_pkg::*;
#(
  parameter int IL    = IL_DEF,
  parameter int FL    = FL_DEF,
  parameter int LANE  = 512,
  parameter int GROUP = 8
);
  localparam int W     = IL + FL;
  localparam int NBEAT = LANE / GROUP;
  localparam int IDX_W = idx_width(NBEAT);

  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     in [LANE][16];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     out [GROUP][16];
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport master (
    input  mode, in_valid, in, out_ready,
    output in_ready, out_valid, out, out_idx, out_last
  );

  modport slave (
    output mode, in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_idx, out_last
  );

endinterface

// File: rtl/dataflow_collect_beat_sel.sv
// Beat slice mux: picks GROUP lanes of the captured frame for a beat index
// and, when ZERO_DET is set, flags a slice whose words are all zero.
module dataflow_beat_sel #(
  parameter int W        = 20,
  parameter int LANE     = 512,
  parameter int GROUP    = 8,
  parameter int IDX_W    = 6,
  parameter bit ZERO_DET = 1'b0
) (
  input  logic signed [W-1:0] frame [LANE][16],
  input  logic [IDX_W-1:0]    beat,
  output logic signed [W-1:0] slice [GROUP][16],
  output logic                all_zero
);

  // Select lanes beat*GROUP .. beat*GROUP+GROUP-1.
  always_comb begin
    slice = '{default: '0};
    for (int g = 0; g < GROUP; g++) begin
      for (int k = 0; k < 16; k++) begin
        slice[g][k] = frame[int'(beat) * GROUP + g][k];
      end
    end
  end

  generate
    if (ZERO_DET) begin : g_zero_det
      // Reduce the whole slice to a single all-zero flag.
      always_comb begin
        all_zero = 1'b1;
        for (int g = 0; g < GROUP; g++) begin
          for (int k = 0; k < 16; k++) begin
            if (slice[g][k] != '0) all_zero = 1'b0;
          end
        end
      end
    end else begin : g_no_zero_det
      assign all_zero = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dataflow_collect.sv
// Dataflow collector: captures a LANE x 16 result frame and drains it as
// GROUP-lane beats over a valid/ready stream (mode 0: beat 0 only,
// mode 1: every beat). Optional build macro DATAFLOW_COLLECT_ZERO_SKIP_EN
// skips all-zero non-final beats in mode 1.
module dataflow_collect
  import dataflow_pkg::*;
#(
  parameter int IL    = IL_DEF,
  parameter int FL    = FL_DEF,
  parameter int LANE  = 512,
  parameter int GROUP = 8
) (
  input  logic              clk,
  input  logic              reset,
  dataflow_collect_if.master bus
);

  localparam int W     = IL + FL;
  localparam int NBEAT = LANE / GROUP;
  localparam int IDX_W = idx_width(NBEAT);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NBEAT - 1);
`ifdef DATAFLOW_COLLECT_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  state_t              state_q;
  logic [IDX_W-1:0]    beat_q;
  logic                mode_q;
  logic signed [W-1:0] frame_q [LANE][16];
  logic signed [W-1:0] slice [GROUP][16];
  logic                all_zero;
  logic                last;
  logic                skip;

  dataflow_beat_sel #(
    .W        (W),
    .LANE     (LANE),
    .GROUP    (GROUP),
    .IDX_W    (IDX_W),
    .ZERO_DET (ZSKIP)
  ) u_beat_sel (
    .frame    (frame_q),
    .beat     (beat_q),
    .slice    (slice),
    .all_zero (all_zero)
  );

  // Broadcast frames end after beat 0; pass-through frames at the final beat.
  assign last = !mode_q || (beat_q == LAST_BEAT);
  // A skipped beat is never presented; the counter steps past it instead.
  assign skip = ZSKIP && (state_q == SEND) && mode_q && (beat_q != LAST_BEAT) && all_zero;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SEND) && !skip;
  assign bus.out_idx   = beat_q;
  assign bus.out_last  = (state_q == SEND) && last;

  // Present the selected slice only while draining; zeros otherwise.
  always_comb begin
    bus.out = '{default: '0};
    if (state_q == SEND) bus.out = slice;
  end

  // Collector FSM: capture in IDLE, step through beats in SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mode_q  <= 1'b0;
      frame_q <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            frame_q <= bus.in;
            mode_q  <= bus.mode;
            beat_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (skip) begin
            beat_q <= beat_q + IDX_W'(1);
          end else if (bus.out_ready) begin
            if (last) begin
              state_q <= IDLE;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataflow_collect.sv
// Self-checking bench for dataflow_collect (LANE=8, GROUP=2, NBEAT=4).
module tb_dataflow_collect;
  import dataflow_pkg::*;

  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int W     = IL + FL;
  localparam int LANE  = 8;
  localparam int GROUP = 2;
  localparam int NBEAT = LANE / GROUP;
  localparam int IDX_W = 2;
`ifdef DATAFLOW_COLLECT_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  typedef struct {
    int idx;
    bit emit;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dataflow_collect_if #(.IL(IL), .FL(FL), .LANE(LANE), .GROUP(GROUP)) bus ();

  dataflow_collect #(.IL(IL), .FL(FL), .LANE(LANE), .GROUP(GROUP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [W-1:0] mframe [LANE][16];
  beat_t exp_q[$];
  int passes = 0;
  int total  = 0;

  // Reference model: the beat sequence a captured frame must produce.
  function automatic void capture_model(input logic m);
    beat_t e;
    bit nz;
    mframe = bus.in;
    exp_q.delete();
    if (!m) begin
      e.idx = 0; e.emit = 1'b1; exp_q.push_back(e);
    end else begin
      for (int b = 0; b < NBEAT; b++) begin
        nz = 1'b0;
        for (int g = 0; g < GROUP; g++)
          for (int k = 0; k < 16; k++)
            if (mframe[b*GROUP+g][k] != 0) nz = 1'b1;
        e.idx  = b;
        e.emit = nz || (b == NBEAT-1) || !ZSKIP;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic bit slice_matches(input int b);
    for (int g = 0; g < GROUP; g++)
      for (int k = 0; k < 16; k++)
        if (bus.out[g][k] !== mframe[b*GROUP+g][k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_pattern();
    for (int j = 0; j < LANE; j++)
      for (int k = 0; k < 16; k++)
        bus.in[j][k] = W'(j*16 + k + 1);
  endtask

  task automatic fill_random(input int zero_pct);
    bit z;
    for (int b = 0; b < NBEAT; b++) begin
      z = ($urandom_range(99) < zero_pct);
      for (int g = 0; g < GROUP; g++)
        for (int k = 0; k < 16; k++)
          bus.in[b*GROUP+g][k] = z ? '0 : W'($urandom);
    end
  endtask

  task automatic test_reset();
    bit zero;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_hold_valid: got %b want 0", bus.out_valid); else passes++;
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", bus.out_valid); else passes++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); else passes++;
    total++; if (bus.out_idx !== IDX_W'(0) || bus.out_last !== 1'b0)
      $display("FAIL post_reset_idx_last: got idx=%0d last=%b want 0 0", bus.out_idx, bus.out_last); else passes++;
    zero = 1'b1;
    for (int g = 0; g < GROUP; g++) for (int k = 0; k < 16; k++) if (bus.out[g][k] !== '0) zero = 1'b0;
    total++; if (!zero) $display("FAIL post_reset_out: got nonzero out want all zero"); else passes++;
  endtask

  task automatic test_mode1();
    int cyc;
    fill_pattern(); bus.mode = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    capture_model(1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(0))
      $display("FAIL first_beat_latency: got valid=%b idx=%0d want 1 0", bus.out_valid, bus.out_idx); else passes++;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      total++; if (bus.out_valid !== 1'b1) $display("FAIL m1_valid: got %b want 1", bus.out_valid); else passes++;
      total++; if (bus.out_idx !== IDX_W'(exp_q[0].idx)) $display("FAIL m1_idx: got %0d want %0d", bus.out_idx, exp_q[0].idx); else passes++;
      total++; if (bus.out_last !== (exp_q.size() == 1)) $display("FAIL m1_last: got %b want %b", bus.out_last, exp_q.size() == 1); else passes++;
      total++; if (!slice_matches(exp_q[0].idx)) $display("FAIL m1_data: beat %0d data differs from frame", exp_q[0].idx); else passes++;
      if (exp_q[0].idx == 2) begin
        total++; if (bus.out[0][0] !== 20'sd65) $display("FAIL m1_lane4_word0: got %0d want 65", bus.out[0][0]); else passes++;
      end
      void'(exp_q.pop_front());
      @(negedge clk); cyc++;
    end
    total++; if (exp_q.size() != 0) $display("FAIL m1_timeout: got %0d beats left want 0", exp_q.size()); else passes++;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL m1_idle_after: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); else passes++;
  endtask

  task automatic test_mode0_back_to_back();
    fill_random(0); bus.mode = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    capture_model(1'b0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(0) || bus.out_last !== 1'b1)
      $display("FAIL m0_a_beat: got valid=%b idx=%0d last=%b want 1 0 1", bus.out_valid, bus.out_idx, bus.out_last); else passes++;
    total++; if (!slice_matches(0)) $display("FAIL m0_a_data: got lanes differ want lanes 0,1"); else passes++;
    fill_random(0);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL m0_gap: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); else passes++;
    capture_model(1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(0) || bus.out_last !== 1'b1)
      $display("FAIL m0_b_beat: got valid=%b idx=%0d last=%b want 1 0 1", bus.out_valid, bus.out_idx, bus.out_last); else passes++;
    total++; if (!slice_matches(0)) $display("FAIL m0_b_data: got lanes differ want lanes 0,1 of frame B"); else passes++;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL m0_b_single: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); else passes++;
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_random(0); bus.mode = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    capture_model(1'b1);
    @(negedge clk);
    total++; if (bus.out_idx !== IDX_W'(0) || !slice_matches(0)) $display("FAIL bp_beat0: got idx=%0d want 0", bus.out_idx); else passes++;
    void'(exp_q.pop_front());
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(1)) $display("FAIL bp_beat1: got valid=%b idx=%0d want 1 1", bus.out_valid, bus.out_idx); else passes++;
    bus.out_ready = 1'b0;
    bus.mode = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(1) || bus.out_last !== 1'b0 || !slice_matches(1))
        $display("FAIL bp_hold: got valid=%b idx=%0d last=%b want 1 1 0 with beat 1 data", bus.out_valid, bus.out_idx, bus.out_last); else passes++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else passes++;
    end
    bus.out_ready = 1'b1;
    void'(exp_q.pop_front());
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge clk); cyc++;
      total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(exp_q[0].idx) || bus.out_last !== (exp_q.size() == 1) || !slice_matches(exp_q[0].idx))
        $display("FAIL bp_resume: got valid=%b idx=%0d last=%b want 1 %0d %b", bus.out_valid, bus.out_idx, bus.out_last, exp_q[0].idx, exp_q.size() == 1); else passes++;
      if (exp_q.size() == 1) bus.in_valid = 1'b0;
      void'(exp_q.pop_front());
    end
    repeat (2) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL bp_no_extra: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); else passes++;
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    fill_random(0); bus.mode = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    capture_model(1'b1);
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(2)) $display("FAIL rmd_at_beat2: got valid=%b idx=%0d want 1 2", bus.out_valid, bus.out_idx); else passes++;
    reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_idx !== IDX_W'(0) || bus.out_last !== 1'b0)
      $display("FAIL rmd_async_clear: got valid=%b idx=%0d last=%b want 0 0 0", bus.out_valid, bus.out_idx, bus.out_last); else passes++;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL rmd_after_release: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); else passes++;
    fill_random(0); bus.in_valid = 1'b1;
    capture_model(1'b1);
    @(negedge clk); bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(0) || !slice_matches(0))
      $display("FAIL rmd_restart: got valid=%b idx=%0d want 1 0 with new frame data", bus.out_valid, bus.out_idx); else passes++;
    void'(exp_q.pop_front());
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge clk); cyc++;
      total++; if (bus.out_idx !== IDX_W'(exp_q[0].idx) || !slice_matches(exp_q[0].idx))
        $display("FAIL rmd_drain: got idx=%0d want %0d", bus.out_idx, exp_q[0].idx); else passes++;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rmd_end_idle: got in_ready=%b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_zero_skip();
    int cyc, emitted;
    fill_pattern();
    for (int k = 0; k < 16; k++) begin
      bus.in[2][k] = '0; bus.in[3][k] = '0; bus.in[6][k] = '0; bus.in[7][k] = '0;
    end
    bus.mode = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    capture_model(1'b1);
    @(negedge clk); bus.in_valid = 1'b0;
    cyc = 0; emitted = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      if (!exp_q[0].emit) begin
        total++; if (bus.out_valid !== 1'b0) $display("FAIL zs_skipped_valid: got %b want 0 at beat %0d", bus.out_valid, exp_q[0].idx); else passes++;
      end else begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(exp_q[0].idx) || bus.out_last !== (exp_q.size() == 1) || !slice_matches(exp_q[0].idx))
          $display("FAIL zs_beat: got valid=%b idx=%0d last=%b want 1 %0d %b", bus.out_valid, bus.out_idx, bus.out_last, exp_q[0].idx, exp_q.size() == 1); else passes++;
        emitted++;
      end
      void'(exp_q.pop_front());
      @(negedge clk); cyc++;
    end
    total++; if (emitted != (ZSKIP ? 3 : 4)) $display("FAIL zs_count: got %0d beats want %0d", emitted, ZSKIP ? 3 : 4); else passes++;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL zs_idle_after: got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); else passes++;
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c < 370) begin
        bus.in_valid  = 1'($urandom_range(1));
        bus.mode      = 1'($urandom_range(1));
        bus.out_ready = ($urandom_range(9) < 7);
        fill_random(30);
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      total++; if (bus.in_ready !== (exp_q.size() == 0)) $display("FAIL rnd_in_ready: got %b want %b", bus.in_ready, exp_q.size() == 0); else passes++;
      if (exp_q.size() == 0) begin
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rnd_idle_valid: got %b want 0", bus.out_valid); else passes++;
        if (bus.in_valid) capture_model(bus.mode);
      end else if (!exp_q[0].emit) begin
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rnd_skip_valid: got %b want 0", bus.out_valid); else passes++;
        void'(exp_q.pop_front());
      end else begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== IDX_W'(exp_q[0].idx) || bus.out_last !== (exp_q.size() == 1) || !slice_matches(exp_q[0].idx))
          $display("FAIL rnd_beat: got valid=%b idx=%0d last=%b want 1 %0d %b", bus.out_valid, bus.out_idx, bus.out_last, exp_q[0].idx, exp_q.size() == 1); else passes++;
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() != 0) $display("FAIL rnd_drained: got %0d beats pending want 0", exp_q.size()); else passes++;
  endtask

  initial begin
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int j = 0; j < LANE; j++) for (int k = 0; k < 16; k++) bus.in[j][k] = '0;
    test_reset();
    test_mode1();
    test_mode0_back_to_back();
    test_backpressure();
    test_reset_mid_drain();
    test_zero_skip();
    test_random_traffic();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dataflow_collect.md
Name: dataflow_collect

Overview:
- Return-path counterpart of the lane distribution stage.
- Captures one full lane x 16 result frame from the PE array and serializes it to the output buffer as GROUP-lane beats over a valid/ready stream.
- mode selects the drain pattern:
  - mode=0 (broadcast mode): only beat 0 is drained.
  - mode=1 (pass-through mode): every beat is drained.

Parameters:
- IL, 4, integer bits of a fixed-point word.
- FL, 16, fractional bits of a fixed-point word; word width W = IL+FL.
- LANE, 512, number of lanes in a frame; must be a multiple of GROUP.
- GROUP, 8, lanes per output beat; NBEAT = LANE/GROUP.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- mode  input  1  drain pattern; sampled only at the frame-capture handshake.
- in_valid  input  1  a result frame is present on in.
- in_ready  output  1  collector can accept a frame.
- in  input  signed W x [LANE][16]  result frame.
- out_valid  output  1  a beat is presented on out.
- out_ready  input  1  downstream accepts the beat.
- out  output  signed W x [GROUP][16]  lanes out_idx*GROUP .. out_idx*GROUP+GROUP-1 of the captured frame.
- out_idx  output  clog2(NBEAT) (minimum 1)  beat index of out.
- out_last  output  1  current beat is the final beat of the frame.

Behaviour:
- States: IDLE, SEND. Reset (async assert) forces:
  - state=IDLE, frame buffer=0, beat counter=0, latched mode=0.
  - out=0, out_valid=0, out_idx=0, out_last=0.
- in_ready = (state==IDLE). It is combinational from state, so it is 1 in the first cycle after reset deasserts.
- IDLE:
  - When in_valid && in_ready: capture in into the frame buffer, latch mode, set beat counter=0, go to SEND.
  - out_valid rises on the next cycle, giving 1-cycle capture-to-first-beat latency.
- SEND:
  - out_valid=1.
  - out = buffer slice at beat counter; out_idx = beat counter.
  - out_last = 1 when latched mode==0, or when beat counter==NBEAT-1.
- Beat handshake when out_valid && out_ready:
  - If out_last: go to IDLE and clear out_valid on the next cycle.
  - Otherwise: increment beat counter and present the next beat on the next cycle. Throughput is 1 beat/cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, out, out_idx and out_last hold stable.
- Input is not accepted during SEND (in_ready=0). in_valid asserted in SEND has no effect and the frame is not consumed.
- Drain lengths:
  - mode=0: exactly 1 beat (lanes 0..GROUP-1).
  - mode=1: exactly NBEAT beats with out_idx 0..NBEAT-1 in order.
- A mode change during SEND does not affect the frame in flight.
- Data words pass unmodified: no arithmetic, no width change, sign preserved.
- Reset asserted mid-drain:
  - Immediate return to IDLE with all outputs cleared.
  - The partial frame is discarded; no further beats of it are emitted.
- Back-to-back frames: a new frame can be captured in the cycle after the last beat handshake. That gives one IDLE cycle per frame.

Optional Feature:
- Macro DATAFLOW_COLLECT_ZERO_SKIP_EN.
- Defined:
  - In mode=1, any non-final beat whose GROUP x 16 words are all zero is skipped. It is never presented, and the counter advances past it in the same cycle it would have been selected.
  - out_idx always reports the true beat index, so gaps are visible.
  - Beat NBEAT-1 is always emitted, even if zero, so out_last is always delivered.
  - mode=0 is unaffected.
- Not defined: every beat is emitted as described above. The zero-detect logic is absent.

Decomposition:
- Package dataflow_pkg:
  - IL/FL defaults and a typedef for the signed W-bit word.
  - typedef for a 16-word lane vector.
  - enum for collector state (IDLE, SEND).
- Sub-module dataflow_beat_sel:
  - Combinational slice mux from frame buffer and beat index to GROUP x 16 words.
  - Also produces the all-zero flag, used only under DATAFLOW_COLLECT_ZERO_SKIP_EN.

Test Plan (LANE=8, GROUP=2, NBEAT=4, word(j,k)=j*16+k+1 unless stated):
- Reset and first capture:
  - Hold reset=0 for 3 cycles, then release → out_valid=0, out=0, in_ready=1 in the first post-reset cycle.
  - in_valid pulse → out_valid=1 with out_idx=0 exactly one cycle later.
- mode=1, out_ready held 1:
  - 4 consecutive beats with out_idx 0,1,2,3; beat 2 carries lanes 4,5 (lane 4 word 0 = 65).
  - out_last=1 only on out_idx=3; in_ready returns 1 the cycle after.
- mode=0:
  - Exactly 1 beat with out_idx=0, out_last=1, lanes 0,1.
  - A second frame sent immediately after is accepted and also drains as 1 beat.
- Backpressure in mode=1:
  - out_ready=0 for 5 cycles at beat 1 → out/out_idx/out_last stable all 5 cycles.
  - No beat is lost or duplicated; in_valid held high during SEND is not consumed.
- Reset mid-drain:
  - Assert reset during beat 2 → out_valid falls asynchronously; after release in_ready=1.
  - A new frame starts again at out_idx=0.
- With DATAFLOW_COLLECT_ZERO_SKIP_EN, mode=1:
  - Lanes 2,3 and 6,7 all zero → beats 0, 2, 3 emitted; beat 3 is all zero but emitted with out_last=1.
